alt_ddrx_multi_chan_buffer: RTL and testbench

- Shared dual-port data buffer carved into NUM_CHAN independent FIFO regions of CHAN_DEPTH words each, all in one inferred RAM.
- Per-channel pointers, fill counters, full/empty flags and per-channel flush.
- Selectable 1- or 2-cycle read latency.
- Sits between the controller's write-data/read-return paths and the datapath.
- Replaces the single flat address-driven buffer with channelised, flow-controlled buffering.

---
 rtl/alt_ddrx_buffer_pkg.sv | 35 +++
 rtl/alt_ddrx_buffer_ram.sv | 58 +++++
 rtl/alt_ddrx_multi_chan_buffer.sv | 186 ++++++++++++++++++
 tb/tb_alt_ddrx_multi_chan_buffer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_ddrx_buffer_pkg.sv
// alt_ddrx_buffer_pkg
// Shared definitions for the multi-channel buffer:
//   clog2       - constant-evaluable ceiling log2
//   CW, PTR_W,  - derived widths for the default configuration
//   CNT_W,        (NUM_CHAN=4, CHAN_DEPTH=16); the top recomputes its own
//   ADDR_W        widths from its parameters with clog2
//   rd_stage_t  - read-pipeline stage {valid, chan}; chan is sized for the
//                 largest supported channel select and narrowed at the top
package alt_ddrx_buffer_pkg;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << res) < value) res = res + 1;
        end
        return res;
    endfunction

    localparam int DEF_NUM_CHAN   = 4;
    localparam int DEF_CHAN_DEPTH = 16;

    localparam int CW     = (clog2(DEF_NUM_CHAN) < 1) ? 1 : clog2(DEF_NUM_CHAN);
    localparam int PTR_W  = clog2(DEF_CHAN_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = clog2(DEF_NUM_CHAN) + PTR_W;

    localparam int CHAN_MAX_W = 16;

    typedef struct packed {
        logic                  valid;
        logic [CHAN_MAX_W-1:0] chan;
    } rd_stage_t;

endpackage

// File: rtl/alt_ddrx_buffer_ram.sv
// alt_ddrx_buffer_ram
// Simple dual-port RAM, single clock, registered read, optional second
// output register (REG_OUTPUT=1). Contents are never reset; only the read
// output registers are, so rd_data starts at 0 and holds between reads.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   wr_en/addr/data   - write port
//   rd_en/addr        - read port; data appears 1 (or 2) cycles after rd_en
//   rd_data           - read data, held when no read completes
module alt_ddrx_buffer_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 6,
    parameter int REG_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
    logic [DATA_WIDTH-1:0] q_p1;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // stage 1: registered RAM read
    always_ff @(posedge clk) begin
        if (reset)      q_p1 <= '0;
        else if (rd_en) q_p1 <= mem[rd_addr];
    end

    generate
        if (REG_OUTPUT != 0) begin : g_oreg
            logic                  vld_p1;
            logic [DATA_WIDTH-1:0] q_p2;
            // stage 2: output register, loads only when stage 1 holds a read
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p1 <= 1'b0;
                    q_p2   <= '0;
                end else begin
                    vld_p1 <= rd_en;
                    if (vld_p1) q_p2 <= q_p1;
                end
            end
            assign rd_data = q_p2;
        end else begin : g_noreg
            assign rd_data = q_p1;
        end
    endgenerate

endmodule

// File: rtl/alt_ddrx_multi_chan_buffer.sv
// alt_ddrx_multi_chan_buffer
// One shared RAM split into NUM_CHAN FIFO regions of CHAN_DEPTH words,
// addressed {chan, ptr}. Per-channel write/read pointers, fill counts,
// ready flags and flush. Read data arrives 1 cycle after accept
// (REG_OUTPUT=0) or 2 cycles (REG_OUTPUT=1), one read per cycle.
// Ports:
//   ctl_clk, ctl_reset             - clock, synchronous active-high reset
//   wr_valid/wr_chan/wr_data       - write request; wr_ready per channel
//   rd_req/rd_chan                 - read request; rd_ready per channel
//   rd_data_valid/rd_data/rd_data_chan - returned read data
//   flush_valid/flush_chan         - clears one channel's pointers/count
//   chan_count                     - packed fill levels, channel 0 in LSBs
// Optional (macro ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN):
//   err_overflow/err_underflow     - sticky request-to-not-ready flags
//   err_chan                       - channel of the first error
module alt_ddrx_multi_chan_buffer
    import alt_ddrx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CHAN   = 4,
    parameter int CHAN_DEPTH = 16,
    parameter int REG_OUTPUT = 0,
    localparam int CHW = (clog2(NUM_CHAN) < 1) ? 1 : clog2(NUM_CHAN),
    localparam int PW  = clog2(CHAN_DEPTH),
    localparam int CNW = PW + 1,
    localparam int AW  = clog2(NUM_CHAN) + PW
) (
    input  logic                    ctl_clk,
    input  logic                    ctl_reset,
    input  logic                    wr_valid,
    input  logic [CHW-1:0]          wr_chan,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_CHAN-1:0]     wr_ready,
    input  logic                    rd_req,
    input  logic [CHW-1:0]          rd_chan,
    output logic [NUM_CHAN-1:0]     rd_ready,
    output logic                    rd_data_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [CHW-1:0]          rd_data_chan,
    input  logic                    flush_valid,
    input  logic [CHW-1:0]          flush_chan,
    output logic [NUM_CHAN*CNW-1:0] chan_count
`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
    ,
    output logic                    err_overflow,
    output logic                    err_underflow,
    output logic [CHW-1:0]          err_chan
`endif
);

    logic [PW-1:0]       wptr [NUM_CHAN];
    logic [PW-1:0]       rptr [NUM_CHAN];
    logic [CNW-1:0]      cnt  [NUM_CHAN];
    logic [NUM_CHAN-1:0] wr_sel, rd_sel, fl_hit, wr_hit, rd_hit;
    logic [PW-1:0]       wptr_sel, rptr_sel;
    logic                wr_acc, rd_acc;
    logic [AW-1:0]       wr_addr, rd_addr;

    // Ready depends only on registered counts and the flush compare, so a
    // same-cycle pop never frees a push slot and vice versa.
    always_comb begin
        wr_sel   = '0;
        rd_sel   = '0;
        fl_hit   = '0;
        wr_ready = '0;
        rd_ready = '0;
        wptr_sel = '0;
        rptr_sel = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            wr_sel[c]   = (wr_chan == CHW'(c));
            rd_sel[c]   = (rd_chan == CHW'(c));
            fl_hit[c]   = flush_valid && (flush_chan == CHW'(c));
            wr_ready[c] = (cnt[c] != CNW'(CHAN_DEPTH)) && !fl_hit[c];
            rd_ready[c] = (cnt[c] != '0) && !fl_hit[c];
            if (wr_sel[c]) wptr_sel = wptr[c];
            if (rd_sel[c]) rptr_sel = rptr[c];
        end
    end

    assign wr_acc  = wr_valid && |(wr_sel & wr_ready);
    assign rd_acc  = rd_req && |(rd_sel & rd_ready);
    assign wr_hit  = wr_sel & {NUM_CHAN{wr_acc}};
    assign rd_hit  = rd_sel & {NUM_CHAN{rd_acc}};
    assign wr_addr = AW'({wr_chan, wptr_sel});
    assign rd_addr = AW'({rd_chan, rptr_sel});

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (fl_hit[c]) begin
                    wptr[c] <= '0;
                    rptr[c] <= '0;
                    cnt[c]  <= '0;
                end else begin
                    if (wr_hit[c]) wptr[c] <= wptr[c] + PW'(1);
                    if (rd_hit[c]) rptr[c] <= rptr[c] + PW'(1);
                    if (wr_hit[c] && !rd_hit[c])      cnt[c] <= cnt[c] + CNW'(1);
                    else if (rd_hit[c] && !wr_hit[c]) cnt[c] <= cnt[c] - CNW'(1);
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CHAN; g++) begin : g_cnt
            assign chan_count[g*CNW +: CNW] = cnt[g];
        end
    endgenerate

    alt_ddrx_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (AW),
        .REG_OUTPUT (REG_OUTPUT)
    ) u_ram (
        .clk     (ctl_clk),
        .reset   (ctl_reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    rd_stage_t st_p1, st_out;
    logic      unused_chan_bits;

    // stage 1: valid/chan aligned with the registered RAM read
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            st_p1 <= '0;
        end else begin
            st_p1.valid <= rd_acc;
            if (rd_acc) st_p1.chan <= CHAN_MAX_W'(rd_chan);
        end
    end

    generate
        if (REG_OUTPUT != 0) begin : g_st2
            rd_stage_t st_p2;
            // stage 2: aligned with the RAM output register
            always_ff @(posedge ctl_clk) begin
                if (ctl_reset) begin
                    st_p2 <= '0;
                end else begin
                    st_p2.valid <= st_p1.valid;
                    if (st_p1.valid) st_p2.chan <= st_p1.chan;
                end
            end
            assign st_out = st_p2;
        end else begin : g_st1
            assign st_out = st_p1;
        end
    endgenerate

    assign rd_data_valid    = st_out.valid;
    assign rd_data_chan     = CHW'(st_out.chan);
    assign unused_chan_bits = ^st_out.chan;

`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
    logic wr_err, rd_err;
    assign wr_err = wr_valid && !wr_acc;
    assign rd_err = rd_req && !rd_acc;

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_chan      <= '0;
        end else begin
            if (wr_err) err_overflow  <= 1'b1;
            if (rd_err) err_underflow <= 1'b1;
            // only the first error (no flag yet) records its channel
            if (!err_overflow && !err_underflow && (wr_err || rd_err))
                err_chan <= wr_err ? wr_chan : rd_chan;
        end
    end
`endif

endmodule

// File: tb/tb_alt_ddrx_multi_chan_buffer.sv
// tb_alt_ddrx_multi_chan_buffer
// Directed bench for alt_ddrx_multi_chan_buffer. Two instances share all
// inputs: u_dut0 (REG_OUTPUT=0) and u_dut1 (REG_OUTPUT=1), both with
// NUM_CHAN=4, CHAN_DEPTH=4. Error outputs are checked when
// ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN is defined.
module tb_alt_ddrx_multi_chan_buffer;

    logic        clk = 1'b0;
    logic        ctl_reset;
    logic        wr_valid, rd_req, flush_valid;
    logic [1:0]  wr_chan, rd_chan, flush_chan;
    logic [31:0] wr_data;

    logic [3:0]  wr_ready0, rd_ready0, wr_ready1, rd_ready1;
    logic        rd_data_valid0, rd_data_valid1;
    logic [31:0] rd_data0, rd_data1;
    logic [1:0]  rd_data_chan0, rd_data_chan1;
    logic [11:0] chan_count0, chan_count1;
`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
    logic        err_overflow0, err_underflow0, err_overflow1, err_underflow1;
    logic [1:0]  err_chan0, err_chan1;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_q [8];

    always #5 clk = ~clk;

    alt_ddrx_multi_chan_buffer #(
        .DATA_WIDTH(32), .NUM_CHAN(4), .CHAN_DEPTH(4), .REG_OUTPUT(0)
    ) u_dut0 (
        .ctl_clk       (clk),
        .ctl_reset     (ctl_reset),
        .wr_valid      (wr_valid),
        .wr_chan       (wr_chan),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready0),
        .rd_req        (rd_req),
        .rd_chan       (rd_chan),
        .rd_ready      (rd_ready0),
        .rd_data_valid (rd_data_valid0),
        .rd_data       (rd_data0),
        .rd_data_chan  (rd_data_chan0),
        .flush_valid   (flush_valid),
        .flush_chan    (flush_chan),
        .chan_count    (chan_count0)
`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
        ,
        .err_overflow  (err_overflow0),
        .err_underflow (err_underflow0),
        .err_chan      (err_chan0)
`endif
    );

    alt_ddrx_multi_chan_buffer #(
        .DATA_WIDTH(32), .NUM_CHAN(4), .CHAN_DEPTH(4), .REG_OUTPUT(1)
    ) u_dut1 (
        .ctl_clk       (clk),
        .ctl_reset     (ctl_reset),
        .wr_valid      (wr_valid),
        .wr_chan       (wr_chan),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready1),
        .rd_req        (rd_req),
        .rd_chan       (rd_chan),
        .rd_ready      (rd_ready1),
        .rd_data_valid (rd_data_valid1),
        .rd_data       (rd_data1),
        .rd_data_chan  (rd_data_chan1),
        .flush_valid   (flush_valid),
        .flush_chan    (flush_chan),
        .chan_count    (chan_count1)
`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
        ,
        .err_overflow  (err_overflow1),
        .err_underflow (err_underflow1),
        .err_chan      (err_chan1)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input logic [11:0] cc, input int c);
        return {29'd0, cc[c*3 +: 3]};
    endfunction

    task automatic write_word(input logic [1:0] ch, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        ctl_reset   = 1'b1;
        wr_valid    = 1'b0;
        rd_req      = 1'b0;
        flush_valid = 1'b0;
        wr_chan     = 2'd0;
        rd_chan     = 2'd0;
        flush_chan  = 2'd0;
        wr_data     = '0;
        tick();
        tick();

        // reset state
        check_val("rst_wr_ready", {28'd0, wr_ready0}, 32'hF);
        check_val("rst_rd_ready", {28'd0, rd_ready0}, 32'h0);
        check_val("rst_valid0", {31'd0, rd_data_valid0}, 32'd0);
        check_val("rst_data0", rd_data0, 32'd0);
        check_val("rst_chan0", {30'd0, rd_data_chan0}, 32'd0);
        check_val("rst_count0", {20'd0, chan_count0}, 32'd0);
        check_val("rst_valid1", {31'd0, rd_data_valid1}, 32'd0);
        ctl_reset = 1'b0;
        tick();

        // fill channel 2 and drain it in order
        for (int i = 0; i < 4; i++) write_word(2'd2, 32'hA0 + i);
        check_val("t1_wr_ready", {28'd0, wr_ready0}, 32'hB);
        check_val("t1_count2", cnt_of(chan_count0, 2), 32'd4);
        check_val("t1_rd_ready", {28'd0, rd_ready0}, 32'h4);
        rd_req  = 1'b1;
        rd_chan = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) rd_req = 1'b0;
            check_val("t1_valid", {31'd0, rd_data_valid0}, 32'd1);
            check_val("t1_data", rd_data0, 32'hA0 + i);
            check_val("t1_chan", {30'd0, rd_data_chan0}, 32'd2);
        end
        tick();
        check_val("t1_idle_valid", {31'd0, rd_data_valid0}, 32'd0);
        check_val("t1_hold_data", rd_data0, 32'hA3);
        check_val("t1_count2_empty", cnt_of(chan_count0, 2), 32'd0);

        // full channel 1: same-cycle read and write, write rejected
        for (int i = 0; i < 4; i++) write_word(2'd1, 32'hB0 + i);
        rd_req   = 1'b1;
        rd_chan  = 2'd1;
        wr_valid = 1'b1;
        wr_chan  = 2'd1;
        wr_data  = 32'hCC;
        #1;
        check_val("t2_wr_ready1", {31'd0, wr_ready0[1]}, 32'd0);
        check_val("t2_rd_ready1", {31'd0, rd_ready0[1]}, 32'd1);
        tick();
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        check_val("t2_valid", {31'd0, rd_data_valid0}, 32'd1);
        check_val("t2_data", rd_data0, 32'hB0);
        check_val("t2_count1", cnt_of(chan_count0, 1), 32'd3);

        // channel isolation between 0 and 3
        write_word(2'd0, 32'h10);
        write_word(2'd3, 32'h30);
        write_word(2'd0, 32'h11);
        write_word(2'd3, 32'h31);
        rd_req  = 1'b1;
        rd_chan = 2'd3;
        tick();
        check_val("t3_data_a", rd_data0, 32'h30);
        check_val("t3_chan_a", {30'd0, rd_data_chan0}, 32'd3);
        tick();
        rd_chan = 2'd0;
        check_val("t3_data_b", rd_data0, 32'h31);
        tick();
        check_val("t3_data_c", rd_data0, 32'h10);
        check_val("t3_chan_c", {30'd0, rd_data_chan0}, 32'd0);
        tick();
        rd_req = 1'b0;
        check_val("t3_data_d", rd_data0, 32'h11);
        check_val("t3_valid_d", {31'd0, rd_data_valid0}, 32'd1);

        // flush channel 0 while writing to it
        for (int i = 0; i < 3; i++) write_word(2'd0, 32'h40 + i);
        check_val("t4_count0_pre", cnt_of(chan_count0, 0), 32'd3);
        flush_valid = 1'b1;
        flush_chan  = 2'd0;
        wr_valid    = 1'b1;
        wr_chan     = 2'd0;
        wr_data     = 32'h99;
        #1;
        check_val("t4_wr_ready0_flush", {31'd0, wr_ready0[0]}, 32'd0);
        check_val("t4_rd_ready0_flush", {31'd0, rd_ready0[0]}, 32'd0);
        tick();
        flush_valid = 1'b0;
        wr_valid    = 1'b0;
        #1;
        check_val("t4_count0", cnt_of(chan_count0, 0), 32'd0);
        check_val("t4_rd_ready0", {31'd0, rd_ready0[0]}, 32'd0);
        check_val("t4_wr_ready0", {31'd0, wr_ready0[0]}, 32'd1);
        check_val("t4_count1_kept", cnt_of(chan_count0, 1), 32'd3);

        // two-cycle latency stream on u_dut1
        ctl_reset = 1'b1;
        tick();
        tick();
        ctl_reset = 1'b0;
        check_val("t5_rst_valid1", {31'd0, rd_data_valid1}, 32'd0);
        check_val("t5_rst_data1", rd_data1, 32'd0);
        check_val("t5_rst_count1", {20'd0, chan_count1}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            write_word(2'd0, 32'h60 + i);
            exp_q[i] = 32'h60 + i;
        end
        for (int i = 0; i < 4; i++) begin
            write_word(2'd1, 32'h70 + i);
            exp_q[4+i] = 32'h70 + i;
        end
        for (int t = 0; t < 10; t++) begin
            rd_req  = (t < 8);
            rd_chan = (t < 4) ? 2'd0 : 2'd1;
            tick();
            check_val("t5_valid1", {31'd0, rd_data_valid1}, (t >= 1 && t <= 8) ? 32'd1 : 32'd0);
            check_val("t5_valid0", {31'd0, rd_data_valid0}, (t <= 7) ? 32'd1 : 32'd0);
            if (t >= 1 && t <= 8) begin
                check_val("t5_data1", rd_data1, exp_q[t-1]);
                check_val("t5_chan1", {30'd0, rd_data_chan1}, (t <= 4) ? 32'd0 : 32'd1);
            end
        end
        rd_req = 1'b0;

        // reset in the middle of a read stream squashes in-flight reads
        for (int i = 0; i < 4; i++) write_word(2'd2, 32'h80 + i);
        rd_req  = 1'b1;
        rd_chan = 2'd2;
        tick();
        check_val("t6_valid_e0", {31'd0, rd_data_valid1}, 32'd0);
        tick();
        check_val("t6_valid_e1", {31'd0, rd_data_valid1}, 32'd1);
        check_val("t6_data_e1", rd_data1, 32'h80);
        rd_req    = 1'b0;
        ctl_reset = 1'b1;
        tick();
        check_val("t6_valid_rst", {31'd0, rd_data_valid1}, 32'd0);
        ctl_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t6_valid_after", {31'd0, rd_data_valid1}, 32'd0);
        end
        check_val("t6_count_after", {20'd0, chan_count1}, 32'd0);

`ifdef ALT_DDRX_MULTI_CHAN_BUFFER_ERR_CHK_EN
        // sticky underflow on empty channel 1
        check_val("t7_err_clear", {30'd0, err_overflow0, err_underflow0}, 32'd0);
        rd_req  = 1'b1;
        rd_chan = 2'd1;
        tick();
        rd_chan = 2'd3;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        check_val("t7_underflow", {31'd0, err_underflow0}, 32'd1);
        check_val("t7_overflow", {31'd0, err_overflow0}, 32'd0);
        check_val("t7_err_chan", {30'd0, err_chan0}, 32'd1);
        check_val("t7_underflow1", {31'd0, err_underflow1}, 32'd1);
        ctl_reset = 1'b1;
        tick();
        ctl_reset = 1'b0;
        check_val("t7_err_rst", {30'd0, err_overflow0, err_underflow0}, 32'd0);
        check_val("t7_err_chan_rst", {30'd0, err_chan0}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
